// File: rtl/sign_stream_out.sv
// sign_stream_out: captures a signature snapshot and streams it out MSB-first as WORD_W words over valid/ready.
module sign_stream_out #(
  parameter int SIG_W = 37760,
  parameter int WORD_W = 32,
  localparam int N_WORDS = SIG_W / WORD_W,
  localparam int IDX_W = N_WORDS > 1 ? $clog2(N_WORDS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stream_start,
  input  logic [SIG_W-1:0]  sigma_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              word_last_o,
  output logic [IDX_W-1:0]  word_idx_o,
  output logic              busy_o,
  output logic              stream_end
);
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [SIG_W-1:0] snap_q, snap_d;
  logic send, last, hs;
  assign send = state_q == SEND;
  assign last = send && idx_q == IDX_W'(N_WORDS - 1);
  assign hs = send && word_ready_i;
  // snapshot shifts left on each accepted word, so the current word always sits at the top
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    snap_d = snap_q;
    case (state_q)
      IDLE: if (stream_start) begin
        state_d = SEND;
        idx_d = '0;
        snap_d = sigma_i;
      end
      SEND: if (hs) begin
        state_d = last ? DONE : SEND;
        idx_d = last ? idx_q : idx_q + IDX_W'(1);
        snap_d = snap_q << WORD_W;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
    end
    snap_q <= snap_d;
  end
  assign word_o = send ? snap_q[SIG_W-1 -: WORD_W] : '0;
  assign word_valid_o = send;
  assign word_last_o = last;
  assign word_idx_o = send ? idx_q : '0;
  assign busy_o = send;
  assign stream_end = state_q == DONE;
endmodule

// File: doc/sign_stream_out.md
SIGN_STREAM_OUT -- requirements
Module: sign_stream_out

Interface
REQ-001 SHALL have parameter SIG_W, default 37760, meaning assembled signature width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, meaning output word width in bits; SIG_W SHALL be an integer multiple of WORD_W.
REQ-003 SHALL have derived constant N_WORDS = SIG_W/WORD_W (1180 at defaults) and IDX_W = 11 bits at defaults.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stream_start  input  1  request to serialize sigma_i; level or pulse accepted.
REQ-007 sigma_i  input  SIG_W  assembled signature {h_t, salt, C_star, seed_triangle, Z0..Z3}, MSB = first bit.
REQ-008 word_o  output  WORD_W  current output word.
REQ-009 word_valid_o  output  1  word_o holds a valid word.
REQ-010 word_ready_i  input  1  consumer accepts word_o this cycle.
REQ-011 word_last_o  output  1  word_o is word N_WORDS-1.
REQ-012 word_idx_o  output  IDX_W  index of word currently on word_o.
REQ-013 busy_o  output  1  high in SEND state.
REQ-014 stream_end  output  1  one-cycle pulse after final word accepted.

Function
REQ-015 SHALL implement states IDLE, SEND, DONE.
REQ-016 In IDLE with stream_start=1, SHALL capture sigma_i into an internal SIG_W snapshot register, clear index to 0, and enter SEND next cycle.
REQ-017 Snapshot SHALL be the only data source in SEND; sigma_i changes after capture SHALL NOT affect output.
REQ-018 Word k SHALL equal snapshot[SIG_W-1-k*WORD_W -: WORD_W] (word 0 = top 32 bits of h_t).
REQ-019 In SEND, word_valid_o=1, busy_o=1, word_o/word_idx_o reflect current index k.
REQ-020 Handshake occurs when word_valid_o & word_ready_i; index SHALL advance by 1 only on handshake.
REQ-021 Without handshake, word_o, word_idx_o, word_last_o, word_valid_o SHALL hold stable (no valid retraction).
REQ-022 word_last_o SHALL be 1 iff in SEND and index = N_WORDS-1.
REQ-023 Handshake on last word SHALL move to DONE; word_valid_o=0 in DONE.
REQ-024 In DONE, stream_end=1 for exactly one cycle; next cycle SHALL return to IDLE.
REQ-025 Back-to-back handshakes SHALL sustain one word per cycle; total SEND duration with word_ready_i held high = N_WORDS cycles.
REQ-026 Latency: stream_start sampled in cycle t -> word 0 valid in cycle t+1.
REQ-027 stream_start in SEND or DONE SHALL be ignored; held-high start re-triggers only on return to IDLE.
REQ-028 Index SHALL never exceed N_WORDS-1; no wrap-around in SEND.
REQ-029 word_o SHALL be 0 when word_valid_o=0.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, index=0, word_valid_o=0, word_last_o=0, busy_o=0, stream_end=0, word_o=0, word_idx_o=0.
REQ-031 reset SHALL win over simultaneous stream_start and handshake.
REQ-032 reset mid-SEND SHALL abort the stream with no stream_end pulse; snapshot contents after reset are don't-care.

Verification
REQ-033 Reset, sigma_i with word k = k (32'h0..32'h49B), start pulse, ready=1 -> words 0..1179 in order on consecutive cycles, last asserted at idx 1179, stream_end one cycle after.
REQ-034 Ready toggling pseudo-randomly (50%) -> each word accepted exactly once, outputs stable while ready=0, same sequence as REQ-033.
REQ-035 Change sigma_i to all-ones one cycle after start -> output still matches captured pattern.
REQ-036 Assert stream_start during SEND at idx 500 -> no restart, index continues 501..
REQ-037 Assert reset at idx 700 with ready=1 -> next cycle valid=0, idx=0, no stream_end; new start restarts at word 0.
REQ-038 stream_start held high continuously -> two complete streams separated by DONE+IDLE (2 cycles of valid=0).
